// File: rtl/video_timing_pkg.sv
// Shared raster timing defaults, pattern mode encoding and sync-window helper
// for the video timing / test-pattern generator.
package video_timing_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID    = 2'd0,
        PAT_GRADIENT = 2'd1,
        PAT_BARS     = 2'd2,
        PAT_CHECKER  = 2'd3
    } pat_mode_e;

    // Default 384x288 raster with a 288x224 active window
    localparam int unsigned DEF_TOTAL_COLS       = 384;
    localparam int unsigned DEF_ACTIVE_COLS      = 288;
    localparam int unsigned DEF_FRONT_PORCH_HORZ = 32;
    localparam int unsigned DEF_SYNC_PULSE_HORZ  = 32;
    localparam int unsigned DEF_BACK_PORCH_HORZ  = 32;
    localparam int unsigned DEF_TOTAL_ROWS       = 288;
    localparam int unsigned DEF_ACTIVE_ROWS      = 224;
    localparam int unsigned DEF_FRONT_PORCH_VERT = 48;
    localparam int unsigned DEF_SYNC_PULSE_VERT  = 8;
    localparam int unsigned DEF_BACK_PORCH_VERT  = 8;

    localparam int unsigned DEF_CNT_W          = 10;
    localparam int unsigned DEF_DOT_W          = 8;
    localparam int unsigned DEF_ROW_BITS       = 3;
    localparam int unsigned DEF_ACC_W          = 16;
    localparam int unsigned DEF_COL_STEP       = 228;
    localparam int unsigned DEF_ROW_STEP       = 590;
    localparam int unsigned DEF_BANK_SPLIT_ROW = 112;
    localparam int unsigned DEF_BAR_SHIFT      = 5;
    localparam int unsigned DEF_CHK_SHIFT      = 4;

    localparam int unsigned FRAME_CNT_W = 8;

    // Half-open sync window [start, stop) along one axis
    typedef struct packed {
        logic [31:0] start;
        logic [31:0] stop;
    } sync_win_t;

    function automatic sync_win_t sync_window(input int unsigned active,
                                              input int unsigned front_porch,
                                              input int unsigned pulse);
        sync_win_t w;
        w.start = 32'(active + front_porch);
        w.stop  = 32'(active + front_porch + pulse);
        return w;
    endfunction

endpackage

// File: rtl/video_timing_pattern_gen_if.sv
// Control inputs and registered raster/pattern outputs of the generator;
// master is the generator, slave is the consumer driving the controls.
interface video_timing_pattern_gen_if #(
    parameter int unsigned CNT_W = 10,
    parameter int unsigned DOT_W = 8
);
    import video_timing_pkg::*;

    logic                   i_Enable;
    logic [1:0]             i_Mode;
    logic [DOT_W-1:0]       i_Solid;

    logic                   o_nHSync;
    logic                   o_nVSync;
    logic                   o_HBlank;
    logic                   o_VBlank;
    logic                   o_Active;
    logic [CNT_W-1:0]       o_Col_Count;
    logic [CNT_W-1:0]       o_Row_Count;
    logic [DOT_W-1:0]       o_Dot;
    logic                   o_Bank;
    logic                   o_Frame_Start;
    logic [FRAME_CNT_W-1:0] o_Frame_Count;

    modport master (
        input  i_Enable, i_Mode, i_Solid,
        output o_nHSync, o_nVSync, o_HBlank, o_VBlank, o_Active,
               o_Col_Count, o_Row_Count, o_Dot, o_Bank,
               o_Frame_Start, o_Frame_Count
    );

    modport slave (
        output i_Enable, i_Mode, i_Solid,
        input  o_nHSync, o_nVSync, o_HBlank, o_VBlank, o_Active,
               o_Col_Count, o_Row_Count, o_Dot, o_Bank,
               o_Frame_Start, o_Frame_Count
    );

endinterface

// File: rtl/video_raster_counter.sv
// Column/row raster counter pair with enable, wrap strobes and a registered
// frame-start pulse aligned with the generator's output registers.
module video_raster_counter #(
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned TOTAL_COLS = 384,
    parameter int unsigned TOTAL_ROWS = 288
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] h_o,
    output logic [CNT_W-1:0] v_o,
    output logic             line_wrap_c,
    output logic             frame_wrap_c,
    output logic             frame_start_o
);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             frame_start_q, frame_start_d;

    // Wrap strobes describe the current position; the caller qualifies them with enable
    always_comb begin
        line_wrap_c   = (32'(h_q) == TOTAL_COLS - 1);
        frame_wrap_c  = line_wrap_c && (32'(v_q) == TOTAL_ROWS - 1);
        frame_start_d = (h_q == '0) && (v_q == '0);
        h_d           = line_wrap_c ? '0 : h_q + CNT_W'(1);
        v_d           = v_q;
        if (line_wrap_c) begin
            v_d = frame_wrap_c ? '0 : v_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q           <= '0;
            v_q           <= '0;
            frame_start_q <= 1'b0;
        end else if (en_i) begin
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_o           = h_q;
    assign v_o           = v_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/video_timing_pattern_gen.sv
// Raster timing and test-pattern source: decodes the (col,row) position into
// syncs, blanking, CLUT bank and a mode-selected dot index, all registered.
module video_timing_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned TOTAL_COLS       = DEF_TOTAL_COLS,
    parameter int unsigned ACTIVE_COLS      = DEF_ACTIVE_COLS,
    parameter int unsigned FRONT_PORCH_HORZ = DEF_FRONT_PORCH_HORZ,
    parameter int unsigned SYNC_PULSE_HORZ  = DEF_SYNC_PULSE_HORZ,
    parameter int unsigned BACK_PORCH_HORZ  = DEF_BACK_PORCH_HORZ,
    parameter int unsigned TOTAL_ROWS       = DEF_TOTAL_ROWS,
    parameter int unsigned ACTIVE_ROWS      = DEF_ACTIVE_ROWS,
    parameter int unsigned FRONT_PORCH_VERT = DEF_FRONT_PORCH_VERT,
    parameter int unsigned SYNC_PULSE_VERT  = DEF_SYNC_PULSE_VERT,
    parameter int unsigned BACK_PORCH_VERT  = DEF_BACK_PORCH_VERT,
    parameter int unsigned CNT_W            = DEF_CNT_W,
    parameter int unsigned DOT_W            = DEF_DOT_W,
    parameter int unsigned ROW_BITS         = DEF_ROW_BITS,
    parameter int unsigned ACC_W            = DEF_ACC_W,
    parameter int unsigned COL_STEP         = DEF_COL_STEP,
    parameter int unsigned ROW_STEP         = DEF_ROW_STEP,
    parameter int unsigned BANK_SPLIT_ROW   = DEF_BANK_SPLIT_ROW,
    parameter int unsigned BAR_SHIFT        = DEF_BAR_SHIFT,
    parameter int unsigned CHK_SHIFT        = DEF_CHK_SHIFT
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    video_timing_pattern_gen_if.master vid
);

    localparam sync_win_t H_SYNC = sync_window(ACTIVE_COLS, FRONT_PORCH_HORZ, SYNC_PULSE_HORZ);
    localparam sync_win_t V_SYNC = sync_window(ACTIVE_ROWS, FRONT_PORCH_VERT, SYNC_PULSE_VERT);
    localparam int unsigned COL_BITS = DOT_W - ROW_BITS;

    if (ACTIVE_COLS + FRONT_PORCH_HORZ + SYNC_PULSE_HORZ + BACK_PORCH_HORZ != TOTAL_COLS) begin : g_bad_h_layout
        $error("horizontal active+porches+sync does not equal TOTAL_COLS");
    end
    if (ACTIVE_ROWS + FRONT_PORCH_VERT + SYNC_PULSE_VERT + BACK_PORCH_VERT != TOTAL_ROWS) begin : g_bad_v_layout
        $error("vertical active+porches+sync does not equal TOTAL_ROWS");
    end
    if ((TOTAL_COLS > (32'd1 << CNT_W)) || (TOTAL_ROWS > (32'd1 << CNT_W))) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TOTAL_COLS/TOTAL_ROWS");
    end
    if ((ROW_BITS >= DOT_W) || (DOT_W > ACC_W)) begin : g_bad_dot_split
        $error("gradient bit split does not fit DOT_W/ACC_W");
    end

    logic [CNT_W-1:0] h, v;
    logic             line_wrap_c, frame_wrap_c;
    logic             frame_start;
    logic             advance;

    assign advance = vid.i_Enable;

    video_raster_counter #(
        .CNT_W      (CNT_W),
        .TOTAL_COLS (TOTAL_COLS),
        .TOTAL_ROWS (TOTAL_ROWS)
    ) u_raster (
        .clk_i         (i_Clk),
        .rst_i         (i_Rst),
        .en_i          (advance),
        .h_o           (h),
        .v_o           (v),
        .line_wrap_c   (line_wrap_c),
        .frame_wrap_c  (frame_wrap_c),
        .frame_start_o (frame_start)
    );

    pat_mode_e              mode_q, mode_d;
    logic [ACC_W-1:0]       col_acc_q, col_acc_d;
    logic [ACC_W-1:0]       row_acc_q, row_acc_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic                   nhsync_q, nhsync_d;
    logic                   nvsync_q, nvsync_d;
    logic                   hblank_q, hblank_d;
    logic                   vblank_q, vblank_d;
    logic                   active_q, active_d;
    logic [CNT_W-1:0]       col_q;
    logic [CNT_W-1:0]       row_q;
    logic [DOT_W-1:0]       dot_q, dot_d;
    logic                   bank_q, bank_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_out_q;

    // Gradient accumulators track c*COL_STEP and the bank-relative r*ROW_STEP
    always_comb begin
        col_acc_d   = line_wrap_c ? '0 : col_acc_q + ACC_W'(COL_STEP);
        row_acc_d   = row_acc_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        if (line_wrap_c) begin
            if (frame_wrap_c || (32'(v) + 32'd1 == BANK_SPLIT_ROW)) begin
                row_acc_d = '0;
            end else begin
                row_acc_d = row_acc_q + ACC_W'(ROW_STEP);
            end
        end
        if (frame_wrap_c) begin
            mode_d      = pat_mode_e'(vid.i_Mode);
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    // Position decode feeding the output registers
    always_comb begin
        hblank_d = (32'(h) >= ACTIVE_COLS);
        vblank_d = (32'(v) >= ACTIVE_ROWS);
        active_d = !hblank_d && !vblank_d;
        nhsync_d = !((32'(h) >= H_SYNC.start) && (32'(h) < H_SYNC.stop));
        nvsync_d = !((32'(v) >= V_SYNC.start) && (32'(v) < V_SYNC.stop));
        bank_d   = (32'(v) >= BANK_SPLIT_ROW) && !vblank_d;
        dot_d    = '0;
        if (active_d) begin
            case (mode_q)
                PAT_SOLID:    dot_d = vid.i_Solid;
                PAT_GRADIENT: dot_d = {row_acc_q[ACC_W-1 -: ROW_BITS],
                                       col_acc_q[ACC_W-1 -: COL_BITS]};
                PAT_BARS:     dot_d = DOT_W'(h >> BAR_SHIFT);
                PAT_CHECKER:  dot_d = (h[CHK_SHIFT] ^ v[CHK_SHIFT]) ? vid.i_Solid : '0;
                default:      dot_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            mode_q          <= pat_mode_e'(vid.i_Mode);
            col_acc_q       <= '0;
            row_acc_q       <= '0;
            frame_cnt_q     <= '0;
            nhsync_q        <= 1'b1;
            nvsync_q        <= 1'b1;
            hblank_q        <= 1'b1;
            vblank_q        <= 1'b1;
            active_q        <= 1'b0;
            col_q           <= '0;
            row_q           <= '0;
            dot_q           <= '0;
            bank_q          <= 1'b0;
            frame_cnt_out_q <= '0;
        end else if (advance) begin
            mode_q          <= mode_d;
            col_acc_q       <= col_acc_d;
            row_acc_q       <= row_acc_d;
            frame_cnt_q     <= frame_cnt_d;
            nhsync_q        <= nhsync_d;
            nvsync_q        <= nvsync_d;
            hblank_q        <= hblank_d;
            vblank_q        <= vblank_d;
            active_q        <= active_d;
            col_q           <= h;
            row_q           <= v;
            dot_q           <= dot_d;
            bank_q          <= bank_d;
            frame_cnt_out_q <= frame_cnt_q;
        end
    end

    assign vid.o_nHSync      = nhsync_q;
    assign vid.o_nVSync      = nvsync_q;
    assign vid.o_HBlank      = hblank_q;
    assign vid.o_VBlank      = vblank_q;
    assign vid.o_Active      = active_q;
    assign vid.o_Col_Count   = col_q;
    assign vid.o_Row_Count   = row_q;
    assign vid.o_Dot         = dot_q;
    assign vid.o_Bank        = bank_q;
    assign vid.o_Frame_Start = frame_start;
    assign vid.o_Frame_Count = frame_cnt_out_q;

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Randomized bench for the timing/pattern generator on a reduced raster,
// compared every clock against a position-arithmetic reference model.
module tb_video_timing_pattern_gen;
    import video_timing_pkg::*;

    localparam int unsigned TC = 96, AC = 72, FPH = 8, SPH = 8, BPH = 8;
    localparam int unsigned TR = 40, AR = 28, FPV = 6, SPV = 3, BPV = 3;
    localparam int unsigned CW = 10, DW = 8, RB = 3, AW = 16;
    localparam int unsigned CS = 228, RS = 590, SPLIT = 20, BSH = 3, CHK = 4;
    localparam int unsigned FRAME = TC * TR;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    video_timing_pattern_gen_if #(.CNT_W(CW), .DOT_W(DW)) vif ();

    video_timing_pattern_gen #(
        .TOTAL_COLS(TC), .ACTIVE_COLS(AC), .FRONT_PORCH_HORZ(FPH),
        .SYNC_PULSE_HORZ(SPH), .BACK_PORCH_HORZ(BPH),
        .TOTAL_ROWS(TR), .ACTIVE_ROWS(AR), .FRONT_PORCH_VERT(FPV),
        .SYNC_PULSE_VERT(SPV), .BACK_PORCH_VERT(BPV),
        .CNT_W(CW), .DOT_W(DW), .ROW_BITS(RB), .ACC_W(AW),
        .COL_STEP(CS), .ROW_STEP(RS), .BANK_SPLIT_ROW(SPLIT),
        .BAR_SHIFT(BSH), .CHK_SHIFT(CHK)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .vid   (vif)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: linear pixel position within the frame
    int        m_pos, m_frames;
    pat_mode_e m_mode;
    logic      e_nh, e_nv, e_hb, e_vb, e_act, e_fs, e_bank;
    int        e_col, e_row, e_dot, e_fc;
    pat_mode_e e_mode;
    int        fs_gap, hs_low;
    bit        fs_seen;

    function automatic int pattern_dot(input int c, input int r, input pat_mode_e md, input int solid);
        int rp, racc, cacc;
        case (md)
            PAT_SOLID:    return solid;
            PAT_GRADIENT: begin
                rp   = (r < int'(SPLIT)) ? r : r - int'(SPLIT);
                racc = (rp * int'(RS)) % (1 << AW);
                cacc = (c * int'(CS)) % (1 << AW);
                return ((racc >> (AW - RB)) << (DW - RB)) | (cacc >> (AW - (DW - RB)));
            end
            PAT_BARS:     return (c >> BSH) % 256;
            default:      return (((c >> CHK) ^ (r >> CHK)) & 1) ? solid : 0;
        endcase
    endfunction

    task automatic step();
        bit        rst_s, en_s;
        pat_mode_e md_s;
        int        sol_s, c, r;
        @(posedge clk);
        rst_s = rst;
        en_s  = vif.i_Enable;
        md_s  = pat_mode_e'(vif.i_Mode);
        sol_s = int'(vif.i_Solid);
        if (rst_s) begin
            {e_nh, e_nv, e_hb, e_vb} = 4'b1111;
            {e_act, e_fs, e_bank}    = 3'b000;
            e_col = 0; e_row = 0; e_dot = 0; e_fc = 0;
            m_pos = 0; m_frames = 0; m_mode = md_s;
            fs_seen = 0; fs_gap = 0; hs_low = 0;
        end else if (en_s) begin
            c = m_pos % TC;
            r = m_pos / TC;
            e_col  = c;
            e_row  = r;
            e_hb   = (c >= int'(AC));
            e_vb   = (r >= int'(AR));
            e_act  = !e_hb && !e_vb;
            e_nh   = !(c >= int'(AC + FPH) && c < int'(AC + FPH + SPH));
            e_nv   = !(r >= int'(AR + FPV) && r < int'(AR + FPV + SPV));
            e_bank = (r >= int'(SPLIT)) && (r < int'(AR));
            e_fs   = (m_pos == 0);
            e_fc   = m_frames;
            e_mode = m_mode;
            e_dot  = e_act ? pattern_dot(c, r, m_mode, sol_s) : 0;
            if (m_pos == int'(FRAME) - 1) begin
                m_pos    = 0;
                m_frames = (m_frames + 1) % 256;
                m_mode   = md_s;
            end else begin
                m_pos++;
            end
        end
        #1;
        check("nHSync", 32'(vif.o_nHSync), 32'(e_nh));
        check("nVSync", 32'(vif.o_nVSync), 32'(e_nv));
        check("HBlank", 32'(vif.o_HBlank), 32'(e_hb));
        check("VBlank", 32'(vif.o_VBlank), 32'(e_vb));
        check("Active", 32'(vif.o_Active), 32'(e_act));
        check("Col_Count", 32'(vif.o_Col_Count), 32'(e_col));
        check("Row_Count", 32'(vif.o_Row_Count), 32'(e_row));
        check("Dot", 32'(vif.o_Dot), 32'(e_dot));
        check("Bank", 32'(vif.o_Bank), 32'(e_bank));
        check("Frame_Start", 32'(vif.o_Frame_Start), 32'(e_fs));
        check("Frame_Count", 32'(vif.o_Frame_Count), 32'(e_fc));
        if (en_s && !rst_s) begin
            fs_gap++;
            if (vif.o_Frame_Start) begin
                if (fs_seen) check("frame_period", 32'(fs_gap), 32'(FRAME));
                fs_gap  = 0;
                fs_seen = 1;
            end
            if (!vif.o_nHSync) hs_low++;
            if (int'(vif.o_Col_Count) == int'(TC) - 1) begin
                check("hsync_width", 32'(hs_low), 32'(SPH));
                hs_low = 0;
            end
            if (e_mode == PAT_GRADIENT) begin
                if (e_row == 0 && e_col == 8)  check("grad_r0_c8", 32'(vif.o_Dot), 32'h00);
                if (e_row == 0 && e_col == 9)  check("grad_r0_c9", 32'(vif.o_Dot), 32'h01);
                if (e_row == 14 && e_col == 0) check("grad_r14_c0", 32'(vif.o_Dot), 32'h20);
                if (e_row == int'(SPLIT) && e_col == 0) begin
                    check("grad_split_bank", 32'(vif.o_Bank), 32'h1);
                    check("grad_split_dot", 32'(vif.o_Dot), 32'h00);
                end
            end
            if (e_mode == PAT_CHECKER && sol_s == 8'hA5) begin
                if (e_row == 0 && e_col == 16)  check("chk_r0_c16", 32'(vif.o_Dot), 32'hA5);
                if (e_row == 16 && e_col == 16) check("chk_r16_c16", 32'(vif.o_Dot), 32'h00);
            end
        end
    endtask

    task automatic run(input int n, input bit rnd_solid, input bit rnd_en, input bit rnd_mode);
        for (int i = 0; i < n; i++) begin
            if (rnd_solid) vif.i_Solid = 8'($urandom);
            if (rnd_en) vif.i_Enable = ($urandom_range(0, 9) != 0);
            if (rnd_mode && $urandom_range(0, 299) == 0) vif.i_Mode = 2'($urandom);
            step();
        end
        vif.i_Enable = 1'b1;
    endtask

    initial begin
        m_pos = 0; m_frames = 0; m_mode = PAT_SOLID; e_mode = PAT_SOLID;
        fs_seen = 0; fs_gap = 0; hs_low = 0;
        rst = 1'b1;
        vif.i_Enable = 1'b1;
        vif.i_Mode   = PAT_GRADIENT;
        vif.i_Solid  = 8'h3C;
        run(3, 0, 0, 0);
        rst = 1'b0;

        // Frame 0 gradient; SOLID requested mid-frame takes effect at the wrap
        run(5 * TC, 0, 0, 0);
        vif.i_Mode = PAT_SOLID;
        run(FRAME - 5 * TC, 0, 0, 0);

        // Frame 1 solid with changing value; CHECKER requested mid-frame
        run(10 * TC, 1, 0, 0);
        vif.i_Mode = PAT_CHECKER;
        run(FRAME - 10 * TC, 1, 0, 0);
        vif.i_Solid = 8'hA5;

        // Frame 2 checker; BARS queued for frame 3
        run(3 * TC, 0, 0, 0);
        vif.i_Mode = PAT_BARS;
        run(FRAME - 3 * TC, 0, 0, 0);

        // Frame 3 bars with a 100-clock freeze mid-line
        run(5 * TC + 50, 1, 0, 0);
        vif.i_Enable = 1'b0;
        run(100, 1, 0, 0);
        run(FRAME - 5 * TC - 50, 1, 0, 0);

        // Random enable gaps, values and mode requests
        run(2 * FRAME, 1, 1, 1);

        // Reset mid-frame with enable low: reset wins
        vif.i_Mode   = PAT_GRADIENT;
        vif.i_Enable = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vif.i_Enable = 1'b1;
        run(FRAME + 30 * TC, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
